// File: rtl/cpu_arb_pkg.sv
// cpu_arb_pkg: shared state encoding, master indices and abort data for the CPU bus arbiter
package cpu_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_D = 2'd1, GNT_I = 2'd2} arb_state_t;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
  localparam logic M_D = 1'b0;
  localparam logic M_I = 1'b1;
endpackage

// File: rtl/cpu_arb_watchdog.sv
// cpu_arb_watchdog: counts grant cycles without ack and flags the abort cycle
module cpu_arb_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [CW-1:0] cnt;
  // cycle counter: restarts on every grant change, holds at the abort value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != LAST) cnt <= cnt + 1'b1;
  assign timeout = (TIMEOUT > 0) && (cnt == LAST);
endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: round-robin sharing of one bus between CPU data and instruction ports
module cpu_bus_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int          AW       = 24,
  parameter int          TIMEOUT  = 1023,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dcpu_cs,
  input  logic          dcpu_we,
  input  logic [3:0]    dcpu_sel,
  input  logic [AW-1:0] dcpu_adr,
  input  logic [31:0]   dcpu_dat_w,
  output logic [31:0]   dcpu_dat_r,
  output logic          dcpu_ack,
  input  logic          icpu_cs,
  input  logic          icpu_we,
  input  logic [3:0]    icpu_sel,
  input  logic [AW-1:0] icpu_adr,
  input  logic [31:0]   icpu_dat_w,
  output logic [31:0]   icpu_dat_r,
  output logic          icpu_ack,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [3:0]    mem_sel,
  output logic [AW-1:0] mem_adr,
  output logic [31:0]   mem_dat_w,
  input  logic [31:0]   mem_dat_r,
  input  logic          mem_ack,
  output logic          gnt_d,
  output logic          gnt_i,
  output logic          err,
  output logic [AW-1:0] err_adr,
  input  logic          err_clr
);
  arb_state_t state, state_next;
  logic last, gd, gi, x_cs, oth_cs, wd_to, wd_clr, wd_en, abort, done;
  assign gd = state == GNT_D;
  assign gi = state == GNT_I;
  assign gnt_d = gd;
  assign gnt_i = gi;
  assign x_cs = (gd & dcpu_cs) | (gi & icpu_cs);
  assign oth_cs = gd ? icpu_cs : dcpu_cs;
  assign abort = x_cs & wd_to & ~mem_ack;
  assign done = x_cs & (mem_ack | wd_to);
  assign wd_clr = state_next != state;
  assign wd_en = (gd | gi) & ~mem_ack;
  cpu_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst_n(rst_n),
    .clr(wd_clr),
    .en(wd_en),
    .timeout(wd_to)
  );
  // grant state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  // arbitration: ties go to the master not served last; a finished master hands over directly
  always_comb begin
    state_next = state;
    if (!gd && !gi)
      state_next = (dcpu_cs && icpu_cs) ? (last == M_I ? GNT_D : GNT_I) :
                   dcpu_cs ? GNT_D : icpu_cs ? GNT_I : IDLE;
    else if (!x_cs) state_next = IDLE;
    else if (done) state_next = oth_cs ? (gd ? GNT_I : GNT_D) : IDLE;
  end
  // bus mux and return path, all zero while nobody holds the grant
  always_comb begin
    mem_cs = x_cs & ~abort;
    mem_we = (gd & dcpu_we) | (gi & icpu_we);
    mem_sel = gd ? dcpu_sel : gi ? icpu_sel : '0;
    mem_adr = gd ? dcpu_adr : gi ? icpu_adr : '0;
    mem_dat_w = gd ? dcpu_dat_w : gi ? icpu_dat_w : '0;
    dcpu_ack = gd & done;
    icpu_ack = gi & done;
    dcpu_dat_r = gd ? (abort ? ERR_DATA : mem_dat_r) : '0;
    icpu_dat_r = gi ? (abort ? ERR_DATA : mem_dat_r) : '0;
  end
  // round-robin memory: remembers who finished last, D wins the first tie after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= M_I;
    else if (done) last <= gi ? M_I : M_D;
  // sticky abort flag; the address latches only for the first abort since the last clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err <= 1'b0;
      err_adr <= '0;
    end else if (abort) begin
      err <= 1'b1;
      if (!err || err_clr) err_adr <= mem_adr;
    end else if (err_clr) begin
      err <= 1'b0;
      err_adr <= '0;
    end
endmodule
